// File: rtl/csoc_scan_seq_pkg.sv
// Shared command bytes, reply bytes and FSM state encoding for the CSoC scan sequencer.
package csoc_scan_seq_pkg;

  // Opcode bytes received from the host.
  localparam logic [7:0] OpReset   = 8'h52;  // 'R'
  localparam logic [7:0] OpTest    = 8'h54;  // 'T'
  localparam logic [7:0] OpScan    = 8'h53;  // 'S'
  localparam logic [7:0] OpCapture = 8'h43;  // 'C'
  localparam logic [7:0] OpPulse   = 8'h50;  // 'P'

  // Reply bytes returned to the host.
  localparam logic [7:0] ReplyOk   = 8'h4B;  // 'K'
  localparam logic [7:0] ReplyErr  = 8'h3F;  // '?'

  // Shared down-counter for the reset pulse and the argument timeout.
  localparam int unsigned TimerW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArg,
    StRst,
    StClkLo,
    StClkHi,
    StReply
  } state_e;

  // Opcodes that are followed by one argument byte.
  function automatic logic op_has_arg(input logic [7:0] op);
    return (op == OpTest) || (op == OpScan) || (op == OpPulse);
  endfunction

endpackage

// File: rtl/csoc_scan_seq_clk_pulse.sv
// Counter-based single csoc_clk pulse: CLK_HALF clocks low, then CLK_HALF clocks high.
// Re-asserting go_i in the done cycle starts the next pulse back to back.
module csoc_clk_pulse #(
  parameter int unsigned CLK_HALF = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic go_i,
  output logic csoc_clk_o,
  output logic rise_o,
  output logic done_o
);

  localparam int unsigned CntW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HALF - 1);

  logic            active_q, active_d;
  logic            clk_q, clk_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_end;

  // Strobes: rise_o marks the cycle whose closing edge drives csoc_clk high.
  always_comb begin
    phase_end = active_q && (cnt_q == CntLast);
    rise_o    = phase_end && !clk_q;
    done_o    = phase_end && clk_q;
  end

  // Next-state for the phase counter and the clock register.
  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    cnt_d    = cnt_q;
    if (go_i) begin
      active_d = 1'b1;
      clk_d    = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (phase_end) begin
        cnt_d = '0;
        clk_d = !clk_q;
        if (clk_q) begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Pulse generator state; csoc_clk comes straight from a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      cnt_q    <= cnt_d;
    end
  end

  assign csoc_clk_o = clk_q;

endmodule

// File: rtl/csoc_scan_seq.sv
// UART-driven CSoC test sequencer: decodes host command bytes into reset pulses,
// test-mode changes, scan-shift cycles and functional clock bursts, one reply per command.
module csoc_scan_seq
  import csoc_scan_seq_pkg::*;
#(
  parameter int unsigned CLK_HALF    = 4,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned ARG_TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_rcv,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       csoc_reset,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic       csoc_clk,
  input  logic [7:0] csoc_data_i,
  output logic [7:0] csoc_data_o,
  output logic       busy
);

  localparam logic [TimerW-1:0] RstLoad = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] ArgLoad = TimerW'(ARG_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        pulses_q, pulses_d;
  logic              tm_q, tm_d;
  logic              se_q, se_d;
  logic [7:0]        data_q, data_d;
  logic              rst_q, rst_d;
  logic [7:0]        tx_data_q, reply_d;
  logic [7:0]        capture_q;
  logic              arm_q, arm_d;
  logic              pulse_go, pulse_rise, pulse_done, pulse_clk;

  csoc_clk_pulse #(
    .CLK_HALF (CLK_HALF)
  ) u_clk_pulse (
    .clk        (clk),
    .rstn       (rstn),
    .go_i       (pulse_go),
    .csoc_clk_o (pulse_clk),
    .rise_o     (pulse_rise),
    .done_o     (pulse_done)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates: decode, argument wait, reset timer, pulse bursts.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    timer_d  = timer_q;
    pulses_d = pulses_q;
    tm_d     = tm_q;
    se_d     = se_q;
    data_d   = data_q;
    rst_d    = rst_q;
    reply_d  = tx_data_q;
    pulse_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_rcv) begin
          op_d = rx_data;
          if (op_has_arg(rx_data)) begin
            state_d = StArg;
            timer_d = ArgLoad;
          end else if (rx_data == OpReset) begin
            state_d = StRst;
            rst_d   = 1'b1;
            timer_d = RstLoad;
          end else if (rx_data == OpCapture) begin
            se_d     = 1'b0;
            pulses_d = 8'd1;
            pulse_go = 1'b1;
            state_d  = StClkLo;
          end else begin
            reply_d = ReplyErr;
            state_d = StReply;
          end
        end
      end
      StArg: begin
        if (rx_rcv) begin
          if (op_q == OpTest) begin
            tm_d    = rx_data[0];
            reply_d = ReplyOk;
            state_d = StReply;
          end else if (op_q == OpScan) begin
            data_d   = rx_data;
            se_d     = 1'b1;
            pulses_d = 8'd1;
            pulse_go = 1'b1;
            state_d  = StClkLo;
          end else begin
            // Pulse burst; a count of zero replies without touching csoc_clk.
            se_d     = 1'b0;
            pulses_d = rx_data;
            if (rx_data == 8'd0) begin
              reply_d = ReplyOk;
              state_d = StReply;
            end else begin
              pulse_go = 1'b1;
              state_d  = StClkLo;
            end
          end
        end else if (timer_q == '0) begin
          reply_d = ReplyErr;
          state_d = StReply;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StRst: begin
        if (timer_q == '0) begin
          rst_d   = 1'b0;
          reply_d = ReplyOk;
          state_d = StReply;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StClkLo: begin
        if (pulse_rise) begin
          state_d = StClkHi;
        end
      end
      StClkHi: begin
        // Falling edge: one pulse consumed.
        if (pulse_done) begin
          pulses_d = pulses_q - 8'd1;
          if (pulses_q == 8'd1) begin
            reply_d = (op_q == OpScan) ? capture_q : ReplyOk;
            state_d = StReply;
          end else begin
            pulse_go = 1'b1;
            state_d  = StClkLo;
          end
        end
      end
      StReply: begin
        if (tx_start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: tx_start waits one settle cycle in REPLY and is gated by tx_ready.
  always_comb begin
    arm_d    = (state_q == StReply) && !tx_start;
    tx_start = (state_q == StReply) && arm_q && tx_ready;
    busy     = (state_q != StIdle);
  end

  // Datapath registers and held test pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q      <= 8'h00;
      timer_q   <= '0;
      pulses_q  <= 8'h00;
      tm_q      <= 1'b0;
      se_q      <= 1'b0;
      data_q    <= 8'h00;
      rst_q     <= 1'b0;
      tx_data_q <= 8'h00;
      arm_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      timer_q   <= timer_d;
      pulses_q  <= pulses_d;
      tm_q      <= tm_d;
      se_q      <= se_d;
      data_q    <= data_d;
      rst_q     <= rst_d;
      tx_data_q <= reply_d;
      arm_q     <= arm_d;
    end
  end

  // Scan-out capture on the edge that raises csoc_clk, so the pre-edge value is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      capture_q <= 8'h00;
    end else if (pulse_rise && (state_q == StClkLo)) begin
      capture_q <= csoc_data_i;
    end
  end

  assign tx_data      = tx_data_q;
  assign csoc_reset   = rst_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign csoc_clk     = pulse_clk;
  assign csoc_data_o  = data_q;

endmodule

// File: tb/tb_csoc_scan_seq.sv
// Directed bench for csoc_scan_seq with a reply scoreboard and pin-activity monitor.
module tb_csoc_scan_seq;

  localparam int unsigned Half = 4;
  localparam int unsigned RstC = 16;
  localparam int unsigned ArgT = 200;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_rcv;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       csoc_reset, csoc_test_se, csoc_test_tm, csoc_clk;
  logic [7:0] csoc_data_i, csoc_data_o;
  logic       busy;

  csoc_scan_seq #(
    .CLK_HALF    (Half),
    .RST_CYCLES  (RstC),
    .ARG_TIMEOUT (ArgT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_rcv       (rx_rcv),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .csoc_reset   (csoc_reset),
    .csoc_test_se (csoc_test_se),
    .csoc_test_tm (csoc_test_tm),
    .csoc_clk     (csoc_clk),
    .csoc_data_i  (csoc_data_i),
    .csoc_data_o  (csoc_data_o),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled 2 time units after the falling edge.
  int         reply_cnt = 0;
  int         tx_cyc = 0;
  logic [7:0] last_tx = 8'h00;
  int         bad_start = 0;
  int         rises = 0;
  int         se_rises = 0;
  int         hi_cyc = 0;
  int         rst_cyc = 0;
  logic       clk_prev = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (tx_start === 1'b1) begin
      reply_cnt++;
      last_tx = tx_data;
      tx_cyc  = cyc;
      if (tx_ready !== 1'b1) bad_start++;
    end
    if (csoc_clk === 1'b1 && clk_prev === 1'b0) begin
      rises++;
      if (csoc_test_se === 1'b1) se_rises++;
    end
    clk_prev = csoc_clk;
    if (csoc_clk === 1'b1) hi_cyc++;
    if (csoc_reset === 1'b1) rst_cyc++;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         n_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    @(negedge clk);
    rx_data = b;
    rx_rcv  = 1'b1;
    t       = cyc;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic expect_reply(input logic [7:0] b);
    exp_q.push_back(b);
    n_exp++;
  endtask

  // Waits (bounded) for the next reply, pops the scoreboard and checks data and latency.
  task automatic wait_reply(input string tag, input int ref_c, input int lat, input int budget);
    int         n;
    logic [7:0] e;
    n = 0;
    while (reply_cnt < n_exp && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk({tag, " reply count"}, reply_cnt, n_exp);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " reply byte"}, {24'h0, last_tx}, {24'h0, e});
    end
    if (lat >= 0) chk({tag, " latency"}, tx_cyc - ref_c, lat);
  endtask

  initial begin
    int t, t2, r0, h0, s0, c0, n;
    rstn        = 1'b0;
    rx_rcv      = 1'b0;
    rx_data     = 8'h00;
    tx_ready    = 1'b1;
    csoc_data_i = 8'h00;
    #1;
    chk("reset outputs", {tx_start, tx_data, csoc_reset, csoc_test_se, csoc_test_tm,
                          csoc_clk, csoc_data_o, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // T 0x01: tm set, busy around the command.
    send_byte(8'h54, t);
    #2;
    chk("busy after opcode", busy, 1'b1);
    expect_reply(8'h4B);
    send_byte(8'h01, t);
    wait_reply("T1", t, 2, 50);
    chk("busy in tx_start cycle", busy, 1'b1);
    chk("tm after T1", csoc_test_tm, 1'b1);
    @(negedge clk);
    #2;
    chk("busy after tx_start", busy, 1'b0);

    // T 0x00
    send_byte(8'h54, t);
    expect_reply(8'h4B);
    send_byte(8'h00, t);
    wait_reply("T0", t, 2, 50);
    chk("tm after T0", csoc_test_tm, 1'b0);

    // S 0xA5: one pulse, capture pre-edge scan-out, later change must not leak in.
    csoc_data_i = 8'h3C;
    r0 = rises; h0 = hi_cyc;
    send_byte(8'h53, t);
    expect_reply(8'h3C);
    send_byte(8'hA5, t);
    n = 0;
    while (csoc_clk !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    csoc_data_i = 8'hFF;
    chk("S data_o", csoc_data_o, 8'hA5);
    chk("S se", csoc_test_se, 1'b1);
    wait_reply("S", t, 2 * Half + 2, 100);
    chk("S pulse count", rises - r0, 1);
    chk("S high width", hi_cyc - h0, Half);

    // C: se cleared, one pulse.
    r0 = rises;
    send_byte(8'h43, t);
    expect_reply(8'h4B);
    wait_reply("C", t, 2 * Half + 2, 100);
    chk("C se", csoc_test_se, 1'b0);
    chk("C pulse count", rises - r0, 1);

    // P 3 and P 0.
    r0 = rises; s0 = se_rises;
    send_byte(8'h50, t);
    expect_reply(8'h4B);
    send_byte(8'h03, t);
    wait_reply("P3", t, 3 * 2 * Half + 2, 200);
    chk("P3 pulse count", rises - r0, 3);
    chk("P3 se low at rises", se_rises - s0, 0);
    r0 = rises;
    send_byte(8'h50, t);
    expect_reply(8'h4B);
    send_byte(8'h00, t);
    wait_reply("P0", t, 2, 50);
    chk("P0 pulse count", rises - r0, 0);

    // R: reset held for exactly RstC clocks.
    c0 = rst_cyc;
    send_byte(8'h52, t);
    expect_reply(8'h4B);
    wait_reply("R", t, RstC + 2, 100);
    chk("R reset width", rst_cyc - c0, RstC);

    // Unknown opcodes: '?' and no pin activity.
    r0 = rises; c0 = rst_cyc;
    send_byte(8'h00, t);
    expect_reply(8'h3F);
    wait_reply("op00", t, 2, 50);
    send_byte(8'h58, t);
    expect_reply(8'h3F);
    wait_reply("opX", t, 2, 50);
    chk("unknown pins", {csoc_test_tm, csoc_test_se, csoc_data_o}, {1'b0, 1'b0, 8'hA5});
    chk("unknown pulses", rises - r0, 0);
    chk("unknown reset", rst_cyc - c0, 0);

    // S then silence: timeout reply, data_o untouched.
    send_byte(8'h53, t);
    expect_reply(8'h3F);
    wait_reply("S timeout", t, -1, ArgT + 50);
    chk("timeout not early", (tx_cyc - t) >= ArgT, 1'b1);
    chk("timeout not late", (tx_cyc - t) <= ArgT + 3, 1'b1);
    chk("timeout pins", {csoc_test_se, csoc_data_o}, {1'b0, 8'hA5});

    // P 0xFF with bytes sent mid-burst; they must be dropped.
    r0 = rises; c0 = rst_cyc;
    send_byte(8'h50, t);
    expect_reply(8'h4B);
    send_byte(8'hFF, t);
    repeat (40) @(negedge clk);
    send_byte(8'h52, t2);
    repeat (30) @(negedge clk);
    send_byte(8'h54, t2);
    wait_reply("P255", t, 255 * 2 * Half + 2, 3000);
    chk("P255 pulse count", rises - r0, 255);
    chk("P255 dropped R", rst_cyc - c0, 0);
    chk("P255 tm", csoc_test_tm, 1'b0);

    // tx_ready low: reply held back until tx_ready returns.
    tx_ready = 1'b0;
    send_byte(8'h54, t);
    expect_reply(8'h4B);
    send_byte(8'h01, t);
    repeat (12) @(negedge clk);
    chk("no reply while not ready", reply_cnt, n_exp - 1);
    tx_ready = 1'b1;
    t2 = cyc;
    wait_reply("ready", t2, 0, 20);

    // Asynchronous reset mid-burst; the pending reply is lost.
    send_byte(8'h50, t);
    send_byte(8'h10, t);
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async reset outputs", {tx_start, tx_data, csoc_reset, csoc_test_se, csoc_test_tm,
                                csoc_clk, csoc_data_o, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    chk("no reply after reset", reply_cnt, n_exp);
    send_byte(8'h54, t);
    expect_reply(8'h4B);
    send_byte(8'h01, t);
    wait_reply("T after reset", t, 2, 50);

    chk("tx_start while not ready", bad_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
